// File: rtl/shift_seq_pkg.sv
// Shared encodings, FSM states and small helpers for the shift operand sequencer.
package shift_seq_pkg;

    localparam int AMT_FULL = 32;

    localparam logic [1:0] MODE_REG    = 2'b00;
    localparam logic [1:0] MODE_ROTIMM = 2'b01;
    localparam logic [1:0] MODE_MEM    = 2'b10;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RS_WAIT = 2'b01,
        ISSUE   = 2'b10
    } seq_state_e;

    // Register-specified shift: data-processing form, bit4 set, bit7 clear.
    function automatic logic needs_rs_f(input logic mem_sel, input logic imm, input logic [11:0] field);
        return !mem_sel && !imm && field[4] && !field[7];
    endfunction

endpackage

// File: rtl/shift_field_decode.sv
// Combinational decode of an operand-2 field (plus Rs byte) into explicit shifter controls,
// folding in the ARM #0 special cases so the shifter itself stays mechanical.
module shift_field_decode
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = 6
) (
    input  logic             mem_sel_i,
    input  logic             imm_i,
    input  logic [11:0]      field_i,
    input  logic [7:0]       rs_byte_i,
    output logic [1:0]       mode_o,
    output logic [1:0]       sh_type_o,
    output logic [AMT_W-1:0] amt_o,
    output logic             rrx_o,
    output logic             illegal_o,
    output logic             needs_rs_o
);

    logic [4:0] imm_amt;

    assign imm_amt    = field_i[11:7];
    assign needs_rs_o = needs_rs_f(mem_sel_i, imm_i, field_i);

    // Field decode, priority mem offset > rotated immediate > immediate shift > register shift.
    always_comb begin
        mode_o    = MODE_REG;
        sh_type_o = SH_LSL;
        amt_o     = '0;
        rrx_o     = 1'b0;
        illegal_o = 1'b0;
        if (mem_sel_i) begin
            mode_o = MODE_MEM;
        end else if (imm_i) begin
            mode_o    = MODE_ROTIMM;
            sh_type_o = SH_ROR;
            amt_o     = AMT_W'({field_i[11:8], 1'b0});
        end else if (!field_i[4]) begin
            sh_type_o = field_i[6:5];
            if (imm_amt != 5'd0) begin
                amt_o = AMT_W'(imm_amt);
            end else begin
                case (field_i[6:5])
                    SH_LSR, SH_ASR: amt_o = AMT_W'(AMT_FULL);
                    SH_ROR:         rrx_o = 1'b1;
                    default:        amt_o = '0;
                endcase
            end
        end else if (field_i[7]) begin
            illegal_o = 1'b1;
        end else begin
            sh_type_o = field_i[6:5];
            if (rs_byte_i == 8'd0) begin
                amt_o = '0;
            end else if (rs_byte_i >= 8'd32) begin
                // Rotation by >=32 is periodic; the linear shifts saturate.
                if (field_i[6:5] == SH_ROR) begin
                    amt_o = AMT_W'(rs_byte_i[4:0]);
                end else begin
                    amt_o = AMT_W'(AMT_FULL);
                end
            end else begin
                amt_o = AMT_W'(rs_byte_i[4:0]);
            end
        end
    end

endmodule

// File: rtl/shift_operand_sequencer.sv
// EXE-stage controller ahead of the Val2 shifter: resolves operand-2 fields into registered
// shifter controls and sequences the extra Rs read for register-specified shifts.
module shift_operand_sequencer
    import shift_seq_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int AMT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mem_sel,
    input  logic             in_imm,
    input  logic [11:0]      in_shift_operand,
    input  logic [IDX_W-1:0] in_rs_idx,
    output logic             rs_req,
    output logic [IDX_W-1:0] rs_idx,
    input  logic             rs_valid,
    input  logic [7:0]       rs_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_mode,
    output logic [1:0]       out_sh_type,
    output logic [AMT_W-1:0] out_sh_amt,
    output logic             out_rrx,
    output logic [11:0]      out_imm12,
    output logic             out_illegal
);

    seq_state_e       state_q, state_d;
    logic             req_mem_sel_q, req_mem_sel_d;
    logic             req_imm_q, req_imm_d;
    logic [11:0]      req_field_q, req_field_d;
    logic [IDX_W-1:0] rs_idx_q, rs_idx_d;
    logic             rs_req_q, rs_req_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       type_q, type_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             rrx_q, rrx_d;
    logic [11:0]      imm12_q, imm12_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             dec_from_req;
    logic             dec_mem_sel, dec_imm;
    logic [11:0]      dec_field;
    logic [7:0]       dec_rs_byte;
    logic [1:0]       dec_mode, dec_type;
    logic [AMT_W-1:0] dec_amt;
    logic             dec_rrx, dec_illegal, dec_needs_rs;

    // One decoder serves both paths: live inputs at accept, the captured request once Rs arrives.
    assign dec_from_req = (state_q == RS_WAIT);
    assign dec_mem_sel  = dec_from_req ? req_mem_sel_q : in_mem_sel;
    assign dec_imm      = dec_from_req ? req_imm_q     : in_imm;
    assign dec_field    = dec_from_req ? req_field_q   : in_shift_operand;
    assign dec_rs_byte  = dec_from_req ? rs_data       : 8'd0;

    shift_field_decode #(.AMT_W(AMT_W)) u_decode (
        .mem_sel_i  (dec_mem_sel),
        .imm_i      (dec_imm),
        .field_i    (dec_field),
        .rs_byte_i  (dec_rs_byte),
        .mode_o     (dec_mode),
        .sh_type_o  (dec_type),
        .amt_o      (dec_amt),
        .rrx_o      (dec_rrx),
        .illegal_o  (dec_illegal),
        .needs_rs_o (dec_needs_rs)
    );

    // Handshake: ready in IDLE or when the issued controls are being consumed; flush blocks accept.
    always_comb begin
        in_ready = 1'b0;
        if (flush) begin
            in_ready = 1'b0;
        end else if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else if ((state_q == ISSUE) && out_ready) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
        accept = in_valid && in_ready;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        req_mem_sel_d = req_mem_sel_q;
        req_imm_d     = req_imm_q;
        req_field_d   = req_field_q;
        rs_idx_d      = rs_idx_q;
        rs_req_d      = rs_req_q;
        out_valid_d   = out_valid_q;
        mode_d        = mode_q;
        type_d        = type_q;
        amt_d         = amt_q;
        rrx_d         = rrx_q;
        imm12_d       = imm12_q;
        illegal_d     = illegal_q;
        if (flush) begin
            state_d       = IDLE;
            req_mem_sel_d = 1'b0;
            req_imm_d     = 1'b0;
            req_field_d   = 12'd0;
            rs_idx_d      = '0;
            rs_req_d      = 1'b0;
            out_valid_d   = 1'b0;
            mode_d        = 2'b00;
            type_d        = 2'b00;
            amt_d         = '0;
            rrx_d         = 1'b0;
            imm12_d       = 12'd0;
            illegal_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE, ISSUE: begin
                    if (accept) begin
                        req_mem_sel_d = in_mem_sel;
                        req_imm_d     = in_imm;
                        req_field_d   = in_shift_operand;
                        rs_idx_d      = in_rs_idx;
                        imm12_d       = in_shift_operand;
                        mode_d        = dec_mode;
                        type_d        = dec_type;
                        amt_d         = dec_amt;
                        rrx_d         = dec_rrx;
                        illegal_d     = dec_illegal;
                        if (dec_needs_rs) begin
                            state_d     = RS_WAIT;
                            rs_req_d    = 1'b1;
                            out_valid_d = 1'b0;
                        end else begin
                            state_d     = ISSUE;
                            rs_req_d    = 1'b0;
                            out_valid_d = 1'b1;
                        end
                    end else if ((state_q == ISSUE) && out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                RS_WAIT: begin
                    if (rs_valid) begin
                        state_d     = ISSUE;
                        rs_req_d    = 1'b0;
                        out_valid_d = 1'b1;
                        mode_d      = dec_mode;
                        type_d      = dec_type;
                        amt_d       = dec_amt;
                        rrx_d       = dec_rrx;
                        illegal_d   = dec_illegal;
                    end else begin
                        state_d = RS_WAIT;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    rs_req_d    = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_mem_sel_q <= 1'b0;
            req_imm_q     <= 1'b0;
            req_field_q   <= 12'd0;
            rs_idx_q      <= '0;
            rs_req_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            mode_q        <= 2'b00;
            type_q        <= 2'b00;
            amt_q         <= '0;
            rrx_q         <= 1'b0;
            imm12_q       <= 12'd0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_mem_sel_q <= req_mem_sel_d;
            req_imm_q     <= req_imm_d;
            req_field_q   <= req_field_d;
            rs_idx_q      <= rs_idx_d;
            rs_req_q      <= rs_req_d;
            out_valid_q   <= out_valid_d;
            mode_q        <= mode_d;
            type_q        <= type_d;
            amt_q         <= amt_d;
            rrx_q         <= rrx_d;
            imm12_q       <= imm12_d;
            illegal_q     <= illegal_d;
        end
    end

    assign rs_req      = rs_req_q;
    assign rs_idx      = rs_idx_q;
    assign out_valid   = out_valid_q;
    assign out_mode    = mode_q;
    assign out_sh_type = type_q;
    assign out_sh_amt  = amt_q;
    assign out_rrx     = rrx_q;
    assign out_imm12   = imm12_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Directed, table-driven bench for shift_operand_sequencer with hand-computed expectations.
module tb_shift_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_mem_sel, in_imm, rs_valid, out_ready;
    logic [11:0] in_shift_operand;
    logic [3:0]  in_rs_idx, rs_idx;
    logic [7:0]  rs_data;
    logic        in_ready, rs_req, out_valid, out_rrx, out_illegal;
    logic [1:0]  out_mode, out_sh_type;
    logic [5:0]  out_sh_amt;
    logic [11:0] out_imm12;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_operand_sequencer #(.IDX_W(4), .AMT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem_sel(in_mem_sel), .in_imm(in_imm),
        .in_shift_operand(in_shift_operand), .in_rs_idx(in_rs_idx),
        .rs_req(rs_req), .rs_idx(rs_idx), .rs_valid(rs_valid), .rs_data(rs_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_sh_type(out_sh_type), .out_sh_amt(out_sh_amt), .out_rrx(out_rrx),
        .out_imm12(out_imm12), .out_illegal(out_illegal)
    );

    typedef struct {
        logic        imm;
        logic        mem_sel;
        logic [11:0] field;
        logic [1:0]  mode;
        logic [1:0]  sh_type;
        logic [5:0]  amt;
        logic        rrx;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] mode, input logic [1:0] ty,
                           input logic [5:0] amt, input logic rrx, input logic ill, input logic [11:0] f);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".mode"}, 32'(out_mode), 32'(mode));
        chk({tag, ".type"}, 32'(out_sh_type), 32'(ty));
        chk({tag, ".amt"}, 32'(out_sh_amt), 32'(amt));
        chk({tag, ".rrx"}, 32'(out_rrx), 32'(rrx));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
        chk({tag, ".imm12"}, 32'(out_imm12), 32'(f));
    endtask

    // Register-shift transaction: Rs returns on the waitc-th RS_WAIT cycle.
    task automatic run_rs(input string tag, input logic [11:0] f, input logic [3:0] idx, input int waitc,
                          input logic [7:0] data, input logic [1:0] ty, input logic [5:0] amt);
        in_valid = 1'b1; in_imm = 1'b0; in_mem_sel = 1'b0; in_shift_operand = f; in_rs_idx = idx;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < waitc; c++) begin
            #1;
            chk({tag, ".rs_req"}, 32'(rs_req), 32'd1);
            chk({tag, ".rs_idx"}, 32'(rs_idx), 32'(idx));
            chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".out_valid_wait"}, 32'(out_valid), 32'd0);
            if (c < waitc - 1) @(negedge clk);
        end
        rs_valid = 1'b1; rs_data = data;
        @(negedge clk);
        rs_valid = 1'b0; rs_data = 8'h00;
        chk({tag, ".rs_req_drop"}, 32'(rs_req), 32'd0);
        chk_out(tag, 2'b00, ty, amt, 1'b0, 1'b0, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 12'h4FF, 2'b01, 2'b11, 6'd8,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 12'h020, 2'b00, 2'b01, 6'd32, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 12'h060, 2'b00, 2'b11, 6'd0,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 12'h000, 2'b00, 2'b00, 6'd0,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 12'h0A0, 2'b00, 2'b01, 6'd1,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 12'hFC0, 2'b00, 2'b10, 6'd31, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 12'hABC, 2'b10, 2'b00, 6'd0,  1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 12'h090, 2'b00, 2'b00, 6'd0,  1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 12'hF00, 2'b01, 2'b11, 6'd30, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 12'h0FF, 2'b01, 2'b11, 6'd0,  1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mem_sel = 1'b0; in_imm = 1'b0;
        in_shift_operand = 12'h000; in_rs_idx = 4'h0; rs_valid = 1'b0; rs_data = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.rs_req", 32'(rs_req), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.amt", 32'(out_sh_amt), 32'd0);
        chk("reset.mode", 32'(out_mode), 32'd0);

        // Back-to-back table, one accept per cycle with no bubble.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_imm = vecs[i].imm; in_mem_sel = vecs[i].mem_sel;
            in_shift_operand = vecs[i].field; in_rs_idx = 4'h0;
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].mode, vecs[i].sh_type, vecs[i].amt,
                    vecs[i].rrx, vecs[i].ill, vecs[i].field);
            chk($sformatf("vec%0d.rs_req", i), 32'(rs_req), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Stray rs_valid while idle must not produce output.
        rs_valid = 1'b1; rs_data = 8'h05;
        @(negedge clk);
        rs_valid = 1'b0;
        chk("stray_rs.out_valid", 32'(out_valid), 32'd0);

        run_rs("rs_asr", 12'h350, 4'd3, 3, 8'h40, 2'b10, 6'd32);
        run_rs("rs_ror", 12'h370, 4'd3, 3, 8'h41, 2'b11, 6'd1);
        run_rs("rs_lsl0", 12'h210, 4'd2, 1, 8'h00, 2'b00, 6'd0);
        run_rs("rs_lsl31", 12'h510, 4'd5, 2, 8'h1F, 2'b00, 6'd31);
        run_rs("rs_lsr_sat", 12'hC30, 4'd12, 1, 8'hFF, 2'b01, 6'd32);

        // Stall: out_ready low with a pending request.
        in_valid = 1'b1; in_imm = 1'b1; in_mem_sel = 1'b0; in_shift_operand = 12'h4FF; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_imm = 1'b0; in_shift_operand = 12'h020;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk_out("stall", 2'b01, 2'b11, 6'd8, 1'b0, 1'b0, 12'h4FF);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("stall_next", 2'b00, 2'b01, 6'd32, 1'b0, 1'b0, 12'h020);

        // Flush in the second RS_WAIT cycle, then a late rs_valid.
        in_valid = 1'b1; in_shift_operand = 12'h350; in_rs_idx = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush.rs_req", 32'(rs_req), 32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready_after", 32'(in_ready), 32'd1);
        rs_valid = 1'b1; rs_data = 8'h40;
        @(negedge clk);
        rs_valid = 1'b0;
        chk("flush.late_rs", 32'(out_valid), 32'd0);

        // Flush beats in_valid in IDLE.
        in_valid = 1'b1; in_imm = 1'b1; in_shift_operand = 12'h4FF; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle.out_valid", 32'(out_valid), 32'd0);
        chk("flush_idle.amt", 32'(out_sh_amt), 32'd0);

        // Reset while in ISSUE with a pending request.
        in_valid = 1'b1; in_imm = 1'b1; in_shift_operand = 12'h4FF; out_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst.valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0; in_imm = 1'b0; in_shift_operand = 12'h020; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_issue.out_valid", 32'(out_valid), 32'd0);
        chk("rst_issue.mode", 32'(out_mode), 32'd0);
        chk("rst_issue.type", 32'(out_sh_type), 32'd0);
        chk("rst_issue.amt", 32'(out_sh_amt), 32'd0);
        chk("rst_issue.imm12", 32'(out_imm12), 32'd0);
        chk("rst_issue.rs_req", 32'(rs_req), 32'd0);
        chk("rst_issue.in_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
